// File: rtl/mod_addsub_pkg.sv
// Shared defaults, reference payload layout and golden model for the pipelined
// modular adder/subtractor.
package mod_addsub_pkg;

  localparam int unsigned DefW = 4;
  localparam int unsigned DefM = 8;

  // Stage-2 payload at the default width. The top declares the same layout at its own W.
  typedef struct packed {
    logic            s;
    logic            r;
    logic [DefW-1:0] m;
    logic [DefW:0]   w;
    logic [DefW:0]   v;
  } stage_t;

  // Golden model for in-range operands (x < m, y < m).
  function automatic int unsigned mod_ref(input logic s, input int unsigned x,
                                          input int unsigned y, input int unsigned m);
    if (m == 0) return 0;
    return s ? (x + m - y) % m : (x + y) % m;
  endfunction

endpackage

// File: rtl/mod_addsub_stage.sv
// Enable-gated valid + payload register with synchronous active-high reset.
module mod_addsub_stage #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic valid_i,
  input  T     data_i,
  output logic valid_o,
  output T     data_o
);

  logic valid_q;
  T     data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mod_addsub_pipe.sv
// Three-stage pipelined modular add/subtract with a run-time loadable modulus
// and valid/ready handshake on both sides.
module mod_addsub_pipe
  import mod_addsub_pkg::*;
#(
  parameter int unsigned W         = DefW,
  parameter int unsigned M_DEFAULT = DefM
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         s,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         m_load,
  input  logic [W-1:0] m_in,
  output logic         m_busy,
  output logic         m_err,
  output logic [W-1:0] m_cur,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] z,
  output logic         range_err
);

  typedef struct packed {
    logic         s;
    logic         r;
    logic [W-1:0] m;
    logic [W:0]   w;
  } s1_t;

  typedef struct packed {
    logic         s;
    logic         r;
    logic [W-1:0] m;
    logic [W:0]   w;
    logic [W:0]   v;
  } s2_t;

  typedef struct packed {
    logic         r;
    logic [W-1:0] z;
  } s3_t;

  logic         en;
  logic         s1_v, s2_v, s3_v;
  s1_t          s1_d, s1_q;
  s2_t          s2_d, s2_q;
  s3_t          s3_d, s3_q;
  logic [W-1:0] m_cur_d, m_cur_q;
  logic         m_err_d, m_err_q;
  logic         m_accept;
  logic         unused_v_msb;

  // Whole pipeline advances together; a stalled output freezes every stage.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage 1: raw sum/difference with carry/borrow in bit W, modulus snapshot.
  always_comb begin
    s1_d   = '0;
    s1_d.s = s;
    s1_d.r = (x >= m_cur_q) || (y >= m_cur_q);
    s1_d.m = m_cur_q;
    s1_d.w = s ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
  end

  // Stage 2: correction candidate.
  always_comb begin
    s2_d   = '0;
    s2_d.s = s1_q.s;
    s2_d.r = s1_q.r;
    s2_d.m = s1_q.m;
    s2_d.w = s1_q.w;
    s2_d.v = s1_q.s ? (s1_q.w + {1'b0, s1_q.m}) : (s1_q.w - {1'b0, s1_q.m});
  end

  // Stage 3: final select.
  always_comb begin
    s3_d = '0;
    if (s2_q.r) begin
      s3_d.r = 1'b1;
    end else if (s2_q.s) begin
      s3_d.z = s2_q.w[W] ? s2_q.v[W-1:0] : s2_q.w[W-1:0];
    end else begin
      s3_d.z = (s2_q.w >= {1'b0, s2_q.m}) ? s2_q.v[W-1:0] : s2_q.w[W-1:0];
    end
  end

  assign unused_v_msb = s2_q.v[W];

  mod_addsub_stage #(.T(s1_t)) u_stage1 (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (en),
    .valid_i (in_valid),
    .data_i  (s1_d),
    .valid_o (s1_v),
    .data_o  (s1_q)
  );

  mod_addsub_stage #(.T(s2_t)) u_stage2 (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (en),
    .valid_i (s1_v),
    .data_i  (s2_d),
    .valid_o (s2_v),
    .data_o  (s2_q)
  );

  mod_addsub_stage #(.T(s3_t)) u_stage3 (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (en),
    .valid_i (s2_v),
    .data_i  (s3_d),
    .valid_o (s3_v),
    .data_o  (s3_q)
  );

  assign out_valid = s3_v;
  assign z         = s3_q.z;
  assign range_err = s3_q.r;

  // Modulus register: loads only into an empty pipeline so no beat sees a mixed m.
  assign m_busy   = s1_v || s2_v || s3_v;
  assign m_accept = m_load && !m_busy && (m_in != '0);

  always_comb begin
    m_cur_d = m_accept ? m_in : m_cur_q;
    m_err_d = m_load && !m_accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_cur_q <= W'(M_DEFAULT);
      m_err_q <= 1'b0;
    end else begin
      m_cur_q <= m_cur_d;
      m_err_q <= m_err_d;
    end
  end

  assign m_cur = m_cur_q;
  assign m_err = m_err_q;

endmodule

// File: doc/mod_addsub_pipe.md
Name: mod_addsub_pipe

Overview:
- Parametrised, pipelined successor of the 4-bit combinational modular adder/subtractor.
- Computes z = (x + y) mod m when s=0, and z = (x − y) mod m when s=1, for W-bit operands.
- Modulus m is held in a run-time loadable register; its reset value comes from a parameter.
- Three registered stages mirror the existing first/second/third stage split: raw sum/difference, correction candidates, final select. Valid/ready handshake on both sides; sits between the operand source and the result consumer.

Parameters:
- W, 4, operand/result/modulus width in bits (W ≥ 2).
- M_DEFAULT, 8, modulus loaded at reset; must satisfy 1 ≤ M_DEFAULT ≤ 2^W−1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts operand beat this cycle.
- s  in  1  0 = add, 1 = subtract.
- x  in  W  operand x, must be < m.
- y  in  W  operand y, must be < m.
- m_load  in  1  request to load new modulus.
- m_in  in  W  new modulus value.
- m_busy  out  1  pipeline non-empty; m_load is ignored while high.
- m_err  out  1  one-cycle pulse: m_load rejected (m_in=0 or m_busy=1).
- m_cur  out  W  current modulus register.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result.
- z  out  W  result.
- range_err  out  1  qualifies z: the beat had x ≥ m or y ≥ m.

Behaviour:
- Reset (rst=1 at a clk edge): all stage valids 0, out_valid=0, z=0, range_err=0, m_err=0, m_cur=M_DEFAULT. Reset wins over every simultaneous event; in-flight beats are discarded.
- Handshake:
  - en = !out_valid || out_ready; in_ready = en.
  - A beat transfers in on in_valid && in_ready, and out on out_valid && out_ready.
  - When en=0 all stages hold; no bubble collapse.
  - out_valid, z and range_err are stable while out_valid && !out_ready.
- Latency: 3 cycles from accepted input to out_valid under no backpressure. Throughput 1 beat/cycle.
- Stage 1: registers s, range flag r = (x ≥ m_cur) || (y ≥ m_cur), and the W+1-bit value w = s ? {0,x} − {0,y} : {0,x} + {0,y}. The carry/borrow sits in bit W.
- Stage 2: registers w and the W+1-bit candidate v:
  - add: v = w − {0,m}.
  - sub: v = w + {0,m}.
- Stage 3 select:
  - add: z = (w ≥ m) ? v[W-1:0] : w[W-1:0].
  - sub: z = w[W] ? v[W-1:0] : w[W-1:0] (w[W] set means borrow).
  - If r=1: z = 0, range_err = 1.
- Modulus snapshot: m is captured into the stage-1 register with each beat, so every beat uses the m that was current at acceptance.
- Modulus load:
  - m_busy = OR of all stage valids, including out_valid.
  - Accepted only when m_load=1, m_busy=0 and m_in≠0; m_cur updates on that edge.
  - If m_load and in_valid arrive in the same cycle with m_busy=0, the load is accepted and the beat uses the OLD m.
  - A rejected load leaves m_cur unchanged and pulses m_err for one cycle.
- m=1 is legal: only x=y=0 is in range, giving z=0.
- All arithmetic is unsigned; no intermediate wider than W+1 bits.

Decomposition:
- Package mod_addsub_pkg holds:
  - default W and M_DEFAULT;
  - the per-stage payload struct (s, r, m, w, v);
  - function mod_ref(s, x, y, m), shared as a golden model by RTL assertions and the bench.
- One sub-module, mod_addsub_stage: an enable-gated valid+payload register with synchronous reset, instantiated three times.
- Arithmetic stays in the top level.

Test Plan:
- W=4, m=8, s=0, x=5, y=6, out_ready=1 → out_valid on cycle 3, z=3, range_err=0.
- s=1, x=2, y=5 → z=5; s=1, x=7, y=7 → z=0; s=0, x=7, y=0 → z=7.
- s=0, x=9, y=1 with m=8 → z=0, range_err=1; the next beat x=1, y=1 → z=2, range_err=0.
- Stream 4 beats, hold out_ready=0 for 5 cycles after the first result → in_ready=0, z held, no beat lost or duplicated; order preserved.
- Idle, m_load=1, m_in=13; then s=0, x=12, y=12 → m_cur=13, z=11.
  - m_load with m_in=0 → m_err pulse, m_cur unchanged.
  - m_load while a beat is in flight → m_err pulse, m_cur unchanged.
- Assert rst with 2 beats in flight and m_cur=13 → next cycle out_valid=0, m_cur=8, in_ready=1; post-reset beat computes correctly.
